// File: rtl/my_counter_pkg.sv
// my_counter_pkg: shared width default, count type and MAX_COUNT default for my_counter
package my_counter_pkg;
   localparam int MY_COUNTER_DEFAULT_WIDTH = 4;
   typedef logic [MY_COUNTER_DEFAULT_WIDTH-1:0] count_t;
   function automatic longint default_max_count(input int width);
      return (longint'(1) << width) - longint'(1);
   endfunction
endpackage

// File: rtl/my_counter_next.sv
// my_counter_next: next-count logic, wraps to 0 or saturates at MAX_COUNT when MY_COUNTER_SAT_EN is defined
module my_counter_next
   import my_counter_pkg::*;
#(
   parameter int               WIDTH     = MY_COUNTER_DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] MAX_COUNT = '1
) (
   input  logic [WIDTH-1:0] cur,
   output logic [WIDTH-1:0] nxt
);
`ifdef MY_COUNTER_SAT_EN
   assign nxt = (cur < MAX_COUNT) ? cur + WIDTH'(1) : MAX_COUNT;
`else
   assign nxt = (cur < MAX_COUNT) ? cur + WIDTH'(1) : '0;
`endif
endmodule

// File: rtl/my_counter.sv
// my_counter: free-running up-counter with async active-low reset; MY_COUNTER_SAT_EN selects saturation instead of wrap
module my_counter
   import my_counter_pkg::*;
#(
   parameter int     WIDTH     = MY_COUNTER_DEFAULT_WIDTH,
   parameter longint MAX_COUNT = default_max_count(WIDTH)
) (
   input  logic             CLK,
   input  logic             RST,
   output logic [WIDTH-1:0] OUT
);
   logic [WIDTH-1:0] cnt, cnt_nxt;
   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $fatal(1, "my_counter: WIDTH %0d outside 1..32", WIDTH);
   end
   if (MAX_COUNT < 1 || MAX_COUNT > default_max_count(WIDTH)) begin : g_bad_max
      $fatal(1, "my_counter: MAX_COUNT %0d outside 1..2**WIDTH-1", MAX_COUNT);
   end
   my_counter_next #(.WIDTH(WIDTH), .MAX_COUNT(MAX_COUNT[WIDTH-1:0])) u_next (
      .cur(cnt),
      .nxt(cnt_nxt)
   );
   always_ff @(posedge CLK or negedge RST)
      if (!RST) cnt <= '0;
      else      cnt <= cnt_nxt;
   assign OUT = cnt;
endmodule

// File: tb/tb_my_counter.sv
// tb_my_counter: scoreboard bench for my_counter at default and MAX_COUNT=9 parameters
module tb_my_counter;
   logic       clk = 1'b0;
   logic       rst_a = 1'bx;
   logic       rst_b = 1'bx;
   logic [3:0] out_a, out_b;
   int         checks = 0;
   int         errors = 0;
   int         q_a[$];
   int         q_b[$];
   int         ea = 0;
   int         eb = 0;

   my_counter dut_a (.CLK(clk), .RST(rst_a), .OUT(out_a));
   my_counter #(.WIDTH(4), .MAX_COUNT(9)) dut_b (.CLK(clk), .RST(rst_b), .OUT(out_b));

   always #50 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, act, exp);
      end
   endtask

   function automatic int step(input int v, input int mx);
`ifdef MY_COUNTER_SAT_EN
      return (v >= mx) ? mx : v + 1;
`else
      return (v >= mx) ? 0 : v + 1;
`endif
   endfunction

   task automatic push(input int n);
      for (int i = 0; i < n; i++) begin
         ea = step(ea, 15);
         eb = step(eb, 9);
         q_a.push_back(ea);
         q_b.push_back(eb);
      end
   endtask

   task automatic edges(input int n);
      repeat (n) begin
         @(negedge clk);
         chk("sb_depth", 32'((q_a.size() > 0) && (q_b.size() > 0)), 1);
         if (q_a.size() > 0 && q_b.size() > 0) begin
            chk("out_a", 32'(out_a), q_a.pop_front());
            chk("out_b", 32'(out_b), q_b.pop_front());
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      #100;
      rst_a = 1'b0;
      rst_b = 1'b0;
      #1;
      chk("rst_async_a", 32'(out_a), 0);
      chk("rst_async_b", 32'(out_b), 0);
      repeat (20) begin
         @(negedge clk);
         chk("rst_hold_a", 32'(out_a), 0);
         chk("rst_hold_b", 32'(out_b), 0);
      end
      rst_a = 1'b1;
      rst_b = 1'b1;
      push(17);
      edges(17);
      @(negedge clk);
      rst_a = 1'b0;
      #1;
      chk("rerst_a", 32'(out_a), 0);
      #1;
      rst_a = 1'b1;
      ea = 0;
      eb = step(eb, 9);
      chk("rerst_b", 32'(out_b), 32'(eb));
      push(9);
      edges(9);
      #25;
      rst_a = 1'b0;
      #1;
      chk("mid_rst_a", 32'(out_a), 0);
      #10;
      rst_a = 1'b1;
      ea = 0;
      push(3);
      edges(3);
      #10;
      force dut_b.cnt = 4'd12;
      #1;
      release dut_b.cnt;
      #1;
      chk("forced_b", 32'(out_b), 12);
      eb = 12;
      push(2);
      edges(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
